// File: rtl/gh_uart_pkg.sv
// gh_uart_pkg: shared UART types, word-length encoding and helper functions.
package gh_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic [1:0] WL5 = 2'b00;
    localparam logic [1:0] WL6 = 2'b01;
    localparam logic [1:0] WL7 = 2'b10;
    localparam logic [1:0] WL8 = 2'b11;

    function automatic logic [3:0] wl_bits(input logic [1:0] num_bits);
        logic [3:0] n;
        n = 4'd8;
        case (num_bits)
            WL5: n = 4'd5;
            WL6: n = 4'd6;
            WL7: n = 4'd7;
            WL8: n = 4'd8;
        endcase
        return n;
    endfunction

    // Even parity is the plain XOR of the word; odd parity is its complement.
    function automatic logic parity(input logic [7:0] data, input logic [3:0] nbits, input logic even);
        logic p;
        p = ~even;
        for (int i = 0; i < 8; i++)
            if (i < int'(nbits)) p = p ^ data[i];
        return p;
    endfunction

endpackage

// File: rtl/gh_uart_tx_ser.sv
// gh_uart_tx_ser: UART transmit serializer, LSB-first with optional parity and 1/2 stop bits.
module gh_uart_tx_ser #(
    parameter int BRC_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       brc,
    input  logic [7:0] d,
    input  logic [1:0] num_bits,
    input  logic       par_en,
    input  logic       par_even,
    input  logic       stop2,
    input  logic       brk,
    input  logic       tx_start,
    output logic       sdo,
    output logic       busy,
    output logic       done
);
    import gh_uart_pkg::*;

    localparam int TW = (BRC_DIV > 2) ? $clog2(BRC_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BRC_DIV - 1);

    tx_state_t   state, state_nxt;
    logic [TW-1:0] tick, tick_nxt;
    logic [2:0]  bit_cnt, bit_nxt;
    logic [7:0]  shreg, sh_nxt;
    logic [1:0]  nb_r;
    logic        par_en_r, par_r, stop2_r;
    logic        sdo_r, sdo_nxt, busy_nxt, done_nxt;
    logic        load, bit_end;
    logic [2:0]  last_bit;

    assign last_bit = 3'(wl_bits(nb_r) - 4'd1);
    assign bit_end  = brc && (tick == TICK_LAST);
    // Break overrides the registered line without disturbing the frame timing.
    assign sdo      = sdo_r & ~brk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick     <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            nb_r     <= '0;
            par_en_r <= 1'b0;
            par_r    <= 1'b0;
            stop2_r  <= 1'b0;
            sdo_r    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
            sdo_r   <= sdo_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            if (load) begin
                nb_r     <= num_bits;
                par_en_r <= par_en;
                par_r    <= parity(d, wl_bits(num_bits), par_even);
                stop2_r  <= stop2;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        sdo_nxt   = sdo_r;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        load      = 1'b0;
        tick_nxt  = (state != IDLE && brc) ? (bit_end ? '0 : tick + TW'(1)) : tick;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    load      = 1'b1;
                    state_nxt = START;
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    sh_nxt    = d;
                    sdo_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    sdo_nxt   = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_nxt = shreg >> 1;
                    if (bit_cnt == last_bit) begin
                        bit_nxt   = '0;
                        state_nxt = par_en_r ? PARITY : STOP;
                        sdo_nxt   = par_en_r ? par_r : 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                        sdo_nxt = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    sdo_nxt   = 1'b1;
                end
            end
            STOP: begin
                // bit_cnt marks the first of two stop bits as already sent.
                if (bit_end) begin
                    if (stop2_r && bit_cnt == 3'd0) begin
                        bit_nxt = 3'd1;
                    end else begin
                        state_nxt = IDLE;
                        bit_nxt   = '0;
                        sdo_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gh_uart_tx_ser.sv
// tb_gh_uart_tx_ser: directed self-checking bench for the UART TX serializer.
module tb_gh_uart_tx_ser;

    logic       clk, rst, brc, par_en, par_even, stop2, brk, tx_start;
    logic [7:0] d;
    logic [1:0] num_bits;
    logic       sdo, busy, done;
    int         n_chk = 0;
    int         n_err = 0;

    gh_uart_tx_ser #(.BRC_DIV(16)) dut (
        .clk(clk), .rst(rst), .brc(brc), .d(d), .num_bits(num_bits),
        .par_en(par_en), .par_even(par_even), .stop2(stop2), .brk(brk),
        .tx_start(tx_start), .sdo(sdo), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe a character at a negedge; config inputs are scrambled after the load edge.
    task automatic send(input logic [7:0] dv, input logic [1:0] nb, input logic pe, input logic pev, input logic s2);
        d        = dv;
        num_bits = nb;
        par_en   = pe;
        par_even = pev;
        stop2    = s2;
        tx_start = 1'b1;
        brc      = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        d        = ~dv;
        num_bits = ~nb;
        par_en   = ~pe;
        par_even = ~pev;
        stop2    = ~s2;
    endtask

    // Walks one frame cycle by cycle: bits[i] is the i-th line bit, per is cycles per bit.
    task automatic frame(input string tag, input logic [11:0] bits, input int nbit, input int per,
                         input int inj, input int blo, input int bhi);
        int   total, bp, good, bsy, dn;
        logic exp_b;
        total = nbit * per;
        bp    = per / 16;
        good  = 0;
        bsy   = 0;
        dn    = 0;
        for (int j = 0; j < total; j++) begin
            brc      = ((j + 1) % bp) == 0;
            tx_start = (j == inj);
            if (j == inj) d = 8'hFF;
            brk      = (j >= blo) && (j < bhi);
            #1;
            exp_b = brk ? 1'b0 : bits[j / per];
            if (sdo === exp_b) good++;
            if (busy === 1'b1) bsy++;
            if (done === 1'b1) dn++;
            if ((j + 1) % per == 0) begin
                check($sformatf("%s bit%0d cycles", tag, j / per), 32'(good), 32'(per));
                good = 0;
            end
            @(negedge clk);
        end
        brc      = 1'b1;
        tx_start = 1'b0;
        brk      = 1'b0;
        #1;
        check({tag, " busy cycles"}, 32'(bsy), 32'(total));
        check({tag, " early done"}, 32'(dn), 0);
        check({tag, " done at end"}, done, 1);
        check({tag, " busy at end"}, busy, 0);
        check({tag, " sdo at end"}, sdo, 1);
    endtask

    initial begin
        int ok;
        rst = 1'b1; brc = 1'b1; brk = 1'b0; tx_start = 1'b1; d = 8'hA5;
        num_bits = 2'b11; par_en = 1'b0; par_even = 1'b0; stop2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst sdo", sdo, 1);
            check("rst busy", busy, 0);
            check("rst done", done, 0);
        end
        rst = 1'b0;
        tx_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sdo === 1'b1 && busy === 1'b0 && done === 1'b0) ok++;
        end
        check("post-rst idle", 32'(ok), 20);

        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        frame("8N1", 12'h2AA, 10, 16, -1, -1, -1);
        @(negedge clk);
        check("8N1 done pulse", done, 0);

        send(8'h83, 2'b10, 1'b1, 1'b1, 1'b0);
        frame("7E1", 12'h206, 10, 16, -1, -1, -1);
        @(negedge clk);

        send(8'h1F, 2'b00, 1'b1, 1'b0, 1'b1);
        frame("5O2", 12'h1BE, 9, 16, -1, -1, -1);
        @(negedge clk);

        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        frame("restrobe", 12'h2AA, 10, 16, 50, -1, -1);
        send(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
        frame("b2b", 12'h200, 10, 16, -1, -1, -1);
        @(negedge clk);
        check("b2b done pulse", done, 0);

        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        frame("brk", 12'h2AA, 10, 16, -1, 40, 90);
        @(negedge clk);

        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        frame("brc/4", 12'h2AA, 10, 64, -1, -1, -1);
        @(negedge clk);

        send(8'h00, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("pre-rst data sdo", sdo, 0);
        check("pre-rst busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("async rst sdo", sdo, 1);
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sdo === 1'b1 && busy === 1'b0 && done === 1'b0) ok++;
        end
        check("no resume after rst", 32'(ok), 200);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
